fechadura_seq_param: RTL and testbench

// - Parametrised successor of the single-code digit-entry lock: compares keypad digits against an N-digit code.
// - Tolerates up to MAX_ERR wrong entries. Only accepts a digit on a rising edge of insere.
// - Drives an error LED, status flags and an active-low 7-segment display.
// - Sits between the debounced keypad/switch inputs and the board display.

---
 rtl/fechadura_seq_param.sv | 156 +++++++++++++++
 tb/tb_fechadura_seq_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fechadura_seq_param.sv
// fechadura_seq_param: parametrised digit-entry lock.
// Keypad digits are compared one at a time against an N_DIG-digit code.
// Up to MAX_ERR wrong entries are tolerated before the lock enters FALHA.
// A digit is taken only on a 0->1 transition of insere.
// Every output is registered.
// The 7-segment output is active-low and ordered {A,B,C,D,E,F,G}.
// Optional feature macro: FECHADURA_LOCKOUT_EN. When it is defined, FALHA
// lasts LOCK_CYCLES clocks and then returns to a fresh ENTRADA. When it is
// undefined, FALHA is held until reset.
module fechadura_seq_param #(
  parameter int N_DIG = 6,
  parameter int DW = 4,
  parameter int MAX_ERR = 1,
  parameter logic [N_DIG*DW-1:0] CODE = 24'h590981,
  parameter int LOCK_CYCLES = 1000,
  localparam int EW = (MAX_ERR > 0) ? $clog2(MAX_ERR + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          insere,
  input  logic [DW-1:0] numero,
  output logic          LED,
  output logic          aberto,
  output logic          falha,
  output logic [EW-1:0] erros,
  output logic [6:0]    seg
);

  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_F     = 7'b0111000;

  typedef enum logic [1:0] {
    ENTRADA = 2'd0,
    ABERTO  = 2'd1,
    FALHA   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [EW-1:0] err_cnt;
  logic          ins_q;
  logic          acc;
  logic [DW-1:0] code_digit;

`ifdef FECHADURA_LOCKOUT_EN
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [LW-1:0] lock_cnt;
`endif

  assign erros = err_cnt;
  assign acc   = insere & ~ins_q;

  // Hex digit to active-low {A,B,C,D,E,F,G} segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Select the expected code digit for the current position.
  // The first digit sits in the most-significant DW bits of CODE.
  always_comb begin
    code_digit = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx == IW'(i)) code_digit = CODE[(N_DIG-1-i)*DW +: DW];
    end
  end

  // Lock state machine. State and all outputs are registered here.
  // ins_q resets to 1, so an insere that is already high at reset release
  // is not taken as a new entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ENTRADA;
      idx     <= '0;
      err_cnt <= '0;
      ins_q   <= 1'b1;
      LED     <= 1'b0;
      aberto  <= 1'b0;
      falha   <= 1'b0;
      seg     <= SEG_BLANK;
`ifdef FECHADURA_LOCKOUT_EN
      lock_cnt <= '0;
`endif
    end else begin
      ins_q <= insere;
      case (state)
        ENTRADA: begin
          if (acc) begin
            seg <= hex_to_seg(4'(numero));
            if (numero == code_digit) begin
              if (idx == IW'(N_DIG - 1)) begin
                state  <= ABERTO;
                aberto <= 1'b1;
                seg    <= (err_cnt == '0) ? SEG_S : SEG_P;
              end else begin
                idx <= idx + IW'(1);
              end
            end else if (err_cnt == EW'(MAX_ERR)) begin
              state <= FALHA;
              falha <= 1'b1;
              seg   <= SEG_F;
`ifdef FECHADURA_LOCKOUT_EN
              lock_cnt <= LW'(LOCK_CYCLES - 1);
`endif
            end else begin
              err_cnt <= err_cnt + EW'(1);
              LED     <= 1'b1;
            end
          end
        end
        ABERTO: begin
        end
        FALHA: begin
`ifdef FECHADURA_LOCKOUT_EN
          if (lock_cnt == '0) begin
            state   <= ENTRADA;
            idx     <= '0;
            err_cnt <= '0;
            LED     <= 1'b0;
            falha   <= 1'b0;
            seg     <= SEG_BLANK;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
`endif
        end
        default: begin
          state <= ENTRADA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fechadura_seq_param.sv
// Directed testbench for fechadura_seq_param using the default code 590981
// and MAX_ERR=1. The lockout scenario is compiled only when
// FECHADURA_LOCKOUT_EN is defined; LOCK_CYCLES is set to 16 here.
module tb_fechadura_seq_param;

  localparam int N_DIG = 6;
  localparam int DW = 4;
  localparam int MAX_ERR = 1;
  localparam int EW = (MAX_ERR > 0) ? $clog2(MAX_ERR + 1) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_D0    = 7'b0000001;
  localparam logic [6:0] SEG_D3    = 7'b0000110;
  localparam logic [6:0] SEG_D5    = 7'b0100100;
  localparam logic [6:0] SEG_D9    = 7'b0000100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          insere = 1'b0;
  logic [DW-1:0] numero = '0;
  logic          LED, aberto, falha;
  logic [EW-1:0] erros;
  logic [6:0]    seg;

  int errors = 0;
  int checks = 0;

  fechadura_seq_param #(
    .N_DIG(N_DIG), .DW(DW), .MAX_ERR(MAX_ERR),
    .CODE(24'h590981), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .insere(insere), .numero(numero),
    .LED(LED), .aberto(aberto), .falha(falha), .erros(erros), .seg(seg)
  );

  always #5 clk = ~clk;

  // One keypad press: raise insere with the digit, drop it a cycle later,
  // and return just after the following rising edge.
  task automatic applyStimulus(input logic [DW-1:0] d);
    @(negedge clk); numero = d; insere = 1'b1;
    @(posedge clk);
    @(negedge clk); insere = 1'b0;
    @(posedge clk); #1;
  endtask

  // Enter the full default code in order.
  task automatic enterCode();
    applyStimulus(4'd5); applyStimulus(4'd9); applyStimulus(4'd0);
    applyStimulus(4'd9); applyStimulus(4'd8); applyStimulus(4'd1);
  endtask

  task automatic doReset();
    @(negedge clk); reset = 1'b1; insere = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (LED !== 1'b0) begin errors++; $display("[TB] FAIL reset_LED: got %b want 0", LED); end
    checks++; if (aberto !== 1'b0) begin errors++; $display("[TB] FAIL reset_aberto: got %b want 0", aberto); end
    checks++; if (falha !== 1'b0) begin errors++; $display("[TB] FAIL reset_falha: got %b want 0", falha); end
    checks++; if (erros !== '0) begin errors++; $display("[TB] FAIL reset_erros: got %0d want 0", erros); end
    checks++; if (seg !== SEG_BLANK) begin errors++; $display("[TB] FAIL reset_seg: got %b want %b", seg, SEG_BLANK); end
  endtask

  task automatic test_open_clean();
    doReset();
    applyStimulus(4'd5);
    checks++; if (seg !== SEG_D5) begin errors++; $display("[TB] FAIL clean_seg5: got %b want %b", seg, SEG_D5); end
    applyStimulus(4'd9); applyStimulus(4'd0);
    checks++; if (seg !== SEG_D0) begin errors++; $display("[TB] FAIL clean_seg0: got %b want %b", seg, SEG_D0); end
    applyStimulus(4'd9); applyStimulus(4'd8);
    checks++; if (aberto !== 1'b0) begin errors++; $display("[TB] FAIL clean_early_open: got %b want 0", aberto); end
    applyStimulus(4'd1);
    checks++; if (aberto !== 1'b1) begin errors++; $display("[TB] FAIL clean_aberto: got %b want 1", aberto); end
    checks++; if (LED !== 1'b0) begin errors++; $display("[TB] FAIL clean_LED: got %b want 0", LED); end
    checks++; if (erros !== '0) begin errors++; $display("[TB] FAIL clean_erros: got %0d want 0", erros); end
    checks++; if (seg !== SEG_S) begin errors++; $display("[TB] FAIL clean_seg_S: got %b want %b", seg, SEG_S); end
    applyStimulus(4'd7);
    checks++; if (seg !== SEG_S || aberto !== 1'b1) begin errors++; $display("[TB] FAIL open_sticky: got seg=%b aberto=%b want %b 1", seg, aberto, SEG_S); end
  endtask

  task automatic test_open_with_error();
    doReset();
    applyStimulus(4'd5); applyStimulus(4'd3);
    checks++; if (LED !== 1'b1) begin errors++; $display("[TB] FAIL err_LED: got %b want 1", LED); end
    checks++; if (erros !== EW'(1)) begin errors++; $display("[TB] FAIL err_erros: got %0d want 1", erros); end
    checks++; if (seg !== SEG_D3) begin errors++; $display("[TB] FAIL err_seg3: got %b want %b", seg, SEG_D3); end
    applyStimulus(4'd9); applyStimulus(4'd0); applyStimulus(4'd9);
    applyStimulus(4'd8); applyStimulus(4'd1);
    checks++; if (aberto !== 1'b1) begin errors++; $display("[TB] FAIL err_aberto: got %b want 1", aberto); end
    checks++; if (erros !== EW'(1)) begin errors++; $display("[TB] FAIL err_erros_open: got %0d want 1", erros); end
    checks++; if (seg !== SEG_P) begin errors++; $display("[TB] FAIL err_seg_P: got %b want %b", seg, SEG_P); end
  endtask

  task automatic test_falha();
    doReset();
    applyStimulus(4'd5); applyStimulus(4'd3); applyStimulus(4'd4);
    checks++; if (falha !== 1'b1) begin errors++; $display("[TB] FAIL falha_flag: got %b want 1", falha); end
    checks++; if (erros !== EW'(1)) begin errors++; $display("[TB] FAIL falha_erros: got %0d want 1", erros); end
    checks++; if (seg !== SEG_F) begin errors++; $display("[TB] FAIL falha_seg: got %b want %b", seg, SEG_F); end
    applyStimulus(4'd9); applyStimulus(4'd0);
    checks++; if (falha !== 1'b1 || aberto !== 1'b0) begin errors++; $display("[TB] FAIL falha_hold: got falha=%b aberto=%b want 1 0", falha, aberto); end
    checks++; if (erros !== EW'(1) || seg !== SEG_F) begin errors++; $display("[TB] FAIL falha_hold_out: got erros=%0d seg=%b want 1 %b", erros, seg, SEG_F); end
  endtask

  task automatic test_hold_insere();
    doReset();
    @(negedge clk); numero = 4'd5; insere = 1'b1;
    repeat (10) @(negedge clk);
    insere = 1'b0;
    @(posedge clk); #1;
    checks++; if (LED !== 1'b0 || seg !== SEG_D5) begin errors++; $display("[TB] FAIL hold_one_accept: got LED=%b seg=%b want 0 %b", LED, seg, SEG_D5); end
    applyStimulus(4'd9);
    checks++; if (LED !== 1'b0 || seg !== SEG_D9) begin errors++; $display("[TB] FAIL hold_idx1: got LED=%b seg=%b want 0 %b", LED, seg, SEG_D9); end
    // insere held high across reset release must not count as a press
    @(negedge clk); reset = 1'b1; insere = 1'b1; numero = 4'd5;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (seg !== SEG_BLANK || LED !== 1'b0) begin errors++; $display("[TB] FAIL reset_held_insere: got seg=%b LED=%b want %b 0", seg, LED, SEG_BLANK); end
    insere = 1'b0;
    applyStimulus(4'd5);
    checks++; if (seg !== SEG_D5 || LED !== 1'b0) begin errors++; $display("[TB] FAIL reaccept: got seg=%b LED=%b want %b 0", seg, LED, SEG_D5); end
  endtask

  task automatic test_reset_mid_entry();
    doReset();
    applyStimulus(4'd5); applyStimulus(4'd9); applyStimulus(4'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (seg !== SEG_BLANK) begin errors++; $display("[TB] FAIL mid_reset_seg: got %b want %b", seg, SEG_BLANK); end
    @(negedge clk); reset = 1'b0;
    enterCode();
    checks++; if (aberto !== 1'b1 || LED !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_open: got aberto=%b LED=%b want 1 0", aberto, LED); end
  endtask

`ifdef FECHADURA_LOCKOUT_EN
  task automatic test_lockout();
    doReset();
    applyStimulus(4'd5); applyStimulus(4'd3); applyStimulus(4'd4);
    // FALHA entered at edge E; now just past E+1
    applyStimulus(4'd5);
    // now just past E+3
    checks++; if (falha !== 1'b1 || seg !== SEG_F) begin errors++; $display("[TB] FAIL lock_ignore: got falha=%b seg=%b want 1 %b", falha, seg, SEG_F); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (falha !== 1'b1) begin errors++; $display("[TB] FAIL lock_e15: got falha=%b want 1", falha); end
    @(posedge clk); #1;
    checks++; if (falha !== 1'b0 || erros !== '0) begin errors++; $display("[TB] FAIL lock_end: got falha=%b erros=%0d want 0 0", falha, erros); end
    checks++; if (LED !== 1'b0 || seg !== SEG_BLANK) begin errors++; $display("[TB] FAIL lock_end_out: got LED=%b seg=%b want 0 %b", LED, seg, SEG_BLANK); end
    enterCode();
    checks++; if (aberto !== 1'b1 || seg !== SEG_S) begin errors++; $display("[TB] FAIL lock_reopen: got aberto=%b seg=%b want 1 %b", aberto, seg, SEG_S); end
  endtask
`endif

  initial begin
    test_reset();
    test_open_clean();
    test_open_with_error();
    test_falha();
    test_hold_insere();
    test_reset_mid_entry();
`ifdef FECHADURA_LOCKOUT_EN
    test_lockout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
